// File: rtl/state_end_gen_if.sv
// Handshake bundle between the phase controller / data source and state_end_gen.
// The master modport is the controller side; the slave modport is state_end_gen.
interface state_end_gen_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       current_state;
    logic             state_update;
    logic             data_valid;
    logic             data_ready;
    logic             state_end;
    logic [CNT_W-1:0] beat_cnt;
    logic             wdog_err;

    modport master (
        output current_state, state_update, data_valid,
        input  data_ready, state_end, beat_cnt, wdog_err
    );

    modport slave (
        input  current_state, state_update, data_valid,
        output data_ready, state_end, beat_cnt, wdog_err
    );
endinterface

// File: rtl/state_end_gen.sv
// Counts accepted beats per convolution phase and pulses state_end when the phase is done.
// Optional WAIT watchdog enabled by defining STATE_END_WDOG_EN; otherwise wdog_err is tied 0.
module state_end_gen #(
    parameter int CNT_W      = 16,
    parameter int INIT_LEN   = 9,
    parameter int ROW_LEN    = 28,
    parameter int WDOG_LIMIT = 255
) (
    input  logic           clk,
    input  logic           rstn,
    state_end_gen_if.slave bus
);

    // A zero length would make the block stall forever, so refuse it at elaboration.
    if (INIT_LEN < 1 || INIT_LEN >= 2**CNT_W || ROW_LEN < 1 || ROW_LEN >= 2**CNT_W ||
        WDOG_LIMIT < 1 || WDOG_LIMIT >= 2**CNT_W) begin : g_bad_cfg
        $error("state_end_gen: length or watchdog parameter out of range");
    end

    localparam logic [CNT_W-1:0] INIT_L = CNT_W'(INIT_LEN);
    localparam logic [CNT_W-1:0] ROW_L  = CNT_W'(ROW_LEN);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_END  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             state_end_q, state_end_d;
    logic [CNT_W-1:0] phase_len;
    logic             ready;
    logic             accept;
`ifdef STATE_END_WDOG_EN
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             wdog_err_q, wdog_err_d;
`endif

    always_comb begin
        unique case (bus.current_state)
            3'b000:                 phase_len = INIT_L;
            3'b001, 3'b010, 3'b011: phase_len = ROW_L;
            default:                phase_len = '0;
        endcase

        // A resync pulse wins over any beat offered in the same cycle.
        ready  = (state_q == ST_RUN) && (phase_len != '0) && !bus.state_update;
        accept = ready && bus.data_valid;

        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
`ifdef STATE_END_WDOG_EN
        wait_cnt_d = wait_cnt_q;
        wdog_err_d = wdog_err_q;
`endif

        unique case (state_q)
            ST_RUN: begin
                if (bus.state_update) begin
                    beat_cnt_d = '0;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + ONE;
                    if (beat_cnt_q == phase_len - ONE) begin
                        state_d = ST_END;
                    end
                end
            end
            ST_END: begin
                if (bus.state_update) begin
                    state_d    = ST_RUN;
                    beat_cnt_d = '0;
                end else begin
                    state_d = ST_WAIT;
`ifdef STATE_END_WDOG_EN
                    wait_cnt_d = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (bus.state_update) begin
                    state_d    = ST_RUN;
                    beat_cnt_d = '0;
                end else begin
`ifdef STATE_END_WDOG_EN
                    wait_cnt_d = wait_cnt_q + ONE;
                    if (wait_cnt_q + ONE == CNT_W'(WDOG_LIMIT)) begin
                        wdog_err_d = 1'b1;
                        state_d    = ST_RUN;
                        beat_cnt_d = '0;
                    end
`endif
                end
            end
            default: begin
                state_d    = ST_RUN;
                beat_cnt_d = '0;
            end
        endcase

        state_end_d = (state_d == ST_END);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_RUN;
            beat_cnt_q  <= '0;
            state_end_q <= 1'b0;
`ifdef STATE_END_WDOG_EN
            wait_cnt_q  <= '0;
            wdog_err_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            state_end_q <= state_end_d;
`ifdef STATE_END_WDOG_EN
            wait_cnt_q  <= wait_cnt_d;
            wdog_err_q  <= wdog_err_d;
`endif
        end
    end

    assign bus.data_ready = ready;
    assign bus.state_end  = state_end_q;
    assign bus.beat_cnt   = beat_cnt_q;
`ifdef STATE_END_WDOG_EN
    assign bus.wdog_err   = wdog_err_q;
`else
    assign bus.wdog_err   = 1'b0;
`endif

endmodule
